// File: rtl/pc_sequencer_if.sv
// Bus between the execute stage / fetch unit and the program-counter sequencer.
// The master drives the control requests and the slave (pc_sequencer) returns the PC state.
interface pc_sequencer_if #(
    parameter int OPD_WIDTH = 32,
    parameter int PC_WIDTH  = 32
);
    logic                 stall;
    logic                 branch;
    logic                 jump;
    logic [OPD_WIDTH-1:0] comp_result;
    logic [OPD_WIDTH-1:0] alu_result;
    logic                 trap;
    logic                 trap_ret;
    logic                 call_push;
    logic                 ret_pop;

    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  next_pc;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic                 fetch_valid;
    logic [PC_WIDTH-1:0]  epc;
    logic                 misaligned;
    logic [PC_WIDTH-1:0]  ras_top;
    logic                 ras_empty;

    modport master (
        output stall, branch, jump, comp_result, alu_result,
               trap, trap_ret, call_push, ret_pop,
        input  pc, next_pc, pc_plus4, fetch_valid, epc, misaligned,
               ras_top, ras_empty
    );

    modport slave (
        input  stall, branch, jump, comp_result, alu_result,
               trap, trap_ret, call_push, ret_pop,
        output pc, next_pc, pc_plus4, fetch_valid, epc, misaligned,
               ras_top, ras_empty
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, trap/return handling and boot FSM.
// Define PC_RAS_EN to build the circular return-address stack (prediction only).
module pc_sequencer #(
    parameter int                  OPD_WIDTH    = 32,
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}},
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100),
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TRAPPED = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] epc_r;
    logic                fetch_valid_r;
    logic                misaligned_r;
    logic [PC_WIDTH-1:0] next_pc_s;
    logic [PC_WIDTH-1:0] pc_plus4_s;
    logic [PC_WIDTH-1:0] target_s;
    logic                redirect_s;
    logic                take_trap_s;
    logic                misaligned_s;

    // Redirect targets are halfword-aligned by dropping bit 0; bit 1 set is a misaligned target.
    function automatic logic [PC_WIDTH-1:0] align_target(input logic [OPD_WIDTH-1:0] addr);
        return addr[PC_WIDTH-1:0] & {{(PC_WIDTH-1){1'b1}}, 1'b0};
    endfunction

    assign pc_plus4_s = pc_r + PC_WIDTH'(4);
    assign target_s   = align_target(bus.alu_result);
    assign redirect_s = bus.jump | (bus.branch & bus.comp_result[0]);

    // Next-state and next-PC selection; stall only blocks redirects, never a trap.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        take_trap_s  = 1'b0;
        misaligned_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                next_state_s = ST_RUN;
                next_pc_s    = RESET_VECTOR;
            end
            ST_RUN: begin
                if (bus.trap) begin
                    next_state_s = ST_TRAPPED;
                    next_pc_s    = TRAP_VECTOR;
                    take_trap_s  = 1'b1;
                end else if (bus.stall) begin
                    next_pc_s = pc_r;
                end else if (bus.trap_ret) begin
                    next_pc_s = epc_r;
                end else if (redirect_s) begin
                    if (target_s[1]) begin
                        next_state_s = ST_TRAPPED;
                        next_pc_s    = TRAP_VECTOR;
                        take_trap_s  = 1'b1;
                        misaligned_s = 1'b1;
                    end else begin
                        next_pc_s = target_s;
                    end
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            ST_TRAPPED: begin
                next_state_s = ST_RUN;
                next_pc_s    = TRAP_VECTOR;
            end
            default: begin
                next_state_s = ST_BOOT;
                next_pc_s    = RESET_VECTOR;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // PC, saved trap PC and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_VECTOR;
            epc_r         <= {PC_WIDTH{1'b0}};
            fetch_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
        end else begin
            pc_r          <= next_pc_s;
            fetch_valid_r <= (next_state_s == ST_RUN);
            misaligned_r  <= misaligned_s;
            if (take_trap_s) begin
                epc_r <= pc_r;
            end else begin
                epc_r <= epc_r;
            end
        end
    end

    assign bus.pc          = pc_r;
    assign bus.next_pc     = next_pc_s;
    assign bus.pc_plus4    = pc_plus4_s;
    assign bus.fetch_valid = fetch_valid_r;
    assign bus.epc         = epc_r;
    assign bus.misaligned  = misaligned_r;

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_tp_r;
    logic [PTR_W:0]      ras_cnt_r;
    logic                ras_push_s;
    logic                ras_pop_s;
    logic                ras_full_s;
    logic                unused_s;

    // Pushes follow a PC advance; a pop on an empty stack is dropped here.
    assign ras_push_s = bus.call_push & (state_r == ST_RUN) & ~bus.stall;
    assign ras_pop_s  = bus.ret_pop & (state_r == ST_RUN) & (ras_cnt_r != {(PTR_W+1){1'b0}});
    assign ras_full_s = (ras_cnt_r == (PTR_W+1)'(RAS_DEPTH));

    // Circular stack: a push when full wraps onto the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_tp_r  <= {PTR_W{1'b0}};
            ras_cnt_r <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (ras_push_s && ras_pop_s) begin
            ras_mem_r[ras_tp_r] <= pc_plus4_s;
        end else if (ras_push_s) begin
            ras_tp_r                          <= ras_tp_r + PTR_W'(1);
            ras_mem_r[ras_tp_r + PTR_W'(1)]   <= pc_plus4_s;
            ras_cnt_r                         <= ras_full_s ? ras_cnt_r : ras_cnt_r + (PTR_W+1)'(1);
        end else if (ras_pop_s) begin
            ras_tp_r  <= ras_tp_r - PTR_W'(1);
            ras_cnt_r <= ras_cnt_r - (PTR_W+1)'(1);
        end else begin
            ras_tp_r  <= ras_tp_r;
            ras_cnt_r <= ras_cnt_r;
        end
    end

    assign bus.ras_empty = (ras_cnt_r == {(PTR_W+1){1'b0}});
    assign bus.ras_top   = bus.ras_empty ? {PC_WIDTH{1'b0}} : ras_mem_r[ras_tp_r];
    assign unused_s      = ^{bus.comp_result, bus.alu_result};
`else
    logic unused_s;

    assign bus.ras_empty = 1'b1;
    assign bus.ras_top   = {PC_WIDTH{1'b0}};
    assign unused_s      = ^{bus.comp_result, bus.alu_result, bus.call_push, bus.ret_pop};
`endif

endmodule
